// File: rtl/multi_request_unit.sv
// multi_request_unit
//   Collects memory read/write requests from NCH channels, latches one per
//   channel, and arbitrates them round-robin onto a single dcache port.
//   dREN/dWEN are held until dhit. The granted channel then gets a one-cycle
//   ch_hit pulse and the load data.
//
//   Optional watchdog: define MULTI_REQUEST_UNIT_TIMEOUT_EN to enable
//   timeout_err, a sticky flag that sets after TIMEOUT ACCESS cycles without
//   dhit. When the macro is not defined, timeout_err is tied to 0.
//
// Ports
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   ihit                 request qualifier
//   ch_memread/ch_memwr  per-channel read/write request      [NCH]
//   ch_addr/ch_wdata     per-channel address/store data      [NCH*AW]/[NCH*DW]
//   ch_busy              per-channel pending flag            [NCH]
//   ch_hit               per-channel completion pulse        [NCH]
//   ch_rdata             load data, valid with ch_hit        [DW]
//   dREN/dWEN/daddr/dstore  dcache request side
//   dhit/dload           dcache completion and load data
//   timeout_err          sticky watchdog flag
module multi_request_unit #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [NCH-1:0]    ch_memread,
    input  logic [NCH-1:0]    ch_memwr,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_busy,
    output logic [NCH-1:0]    ch_hit,
    output logic [DW-1:0]     ch_rdata,
    output logic              dREN,
    output logic              dWEN,
    output logic [AW-1:0]     daddr,
    output logic [DW-1:0]     dstore,
    input  logic              dhit,
    input  logic [DW-1:0]     dload,
    output logic              timeout_err
);

    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state_q;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  capture;
    logic [NCH-1:0]  wr_q;
    logic [AW-1:0]   addr_q  [NCH];
    logic [DW-1:0]   wdata_q [NCH];
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   grant_q;
    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic [NCH-1:0]  ch_hit_q;
    logic [DW-1:0]   ch_rdata_q;
    logic            dren_q, dwen_q;
    logic [AW-1:0]   daddr_q;
    logic [DW-1:0]   dstore_q;
    logic            complete;

    assign complete = (state_q == ACCESS) && dhit;

    // A channel can capture only while it is not pending. So a capture and a
    // completion at the same edge always affect different bits of pending.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            capture[i] = ihit && (ch_memread[i] || ch_memwr[i]) && !pending_q[i];
        end
        pending_d = pending_q | capture;
        if (complete) begin
            pending_d[grant_q] = 1'b0;
        end
    end

    // Round-robin search starts at the channel after last_grant and wraps.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant_q) + k) % NCH;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    // Per-channel request slots. Write wins when both read and write are set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (capture[i]) begin
                    wr_q[i]    <= ch_memwr[i];
                    addr_q[i]  <= ch_addr[i*AW +: AW];
                    wdata_q[i] <= ch_wdata[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            last_grant_q <= GW'(NCH - 1);
            grant_q      <= '0;
            dren_q       <= 1'b0;
            dwen_q       <= 1'b0;
            daddr_q      <= '0;
            dstore_q     <= '0;
            ch_hit_q     <= '0;
            ch_rdata_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            ch_hit_q   <= '0;
            ch_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        grant_q  <= grant_idx;
                        daddr_q  <= addr_q[grant_idx];
                        dstore_q <= wdata_q[grant_idx];
                        dwen_q   <= wr_q[grant_idx];
                        dren_q   <= !wr_q[grant_idx];
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        dren_q            <= 1'b0;
                        dwen_q            <= 1'b0;
                        ch_hit_q[grant_q] <= 1'b1;
                        ch_rdata_q        <= dren_q ? dload : '0;
                        last_grant_q      <= grant_q;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MULTI_REQUEST_UNIT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt_q;
    logic          terr_q;

    // The counter clears on entry to ACCESS and saturates at TIMEOUT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (grant_found) begin
                tcnt_q <= '0;
            end
        end else if (!dhit && (tcnt_q != TW'(TIMEOUT))) begin
            tcnt_q <= tcnt_q + 1'b1;
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                terr_q <= 1'b1;
            end
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign ch_busy  = pending_q;
    assign ch_hit   = ch_hit_q;
    assign ch_rdata = ch_rdata_q;
    assign dREN     = dren_q;
    assign dWEN     = dwen_q;
    assign daddr    = daddr_q;
    assign dstore   = dstore_q;

endmodule

// File: tb/tb_multi_request_unit.sv
module tb_multi_request_unit;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ihit;
    logic [NCH-1:0]    ch_memread;
    logic [NCH-1:0]    ch_memwr;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_busy;
    logic [NCH-1:0]    ch_hit;
    logic [DW-1:0]     ch_rdata;
    logic              dREN;
    logic              dWEN;
    logic [AW-1:0]     daddr;
    logic [DW-1:0]     dstore;
    logic              dhit;
    logic [DW-1:0]     dload;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;

    multi_request_unit #(
        .NCH    (NCH),
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .ch_memread (ch_memread),
        .ch_memwr   (ch_memwr),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_busy    (ch_busy),
        .ch_hit     (ch_hit),
        .ch_rdata   (ch_rdata),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .dhit       (dhit),
        .dload      (dload),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        ihit       = 1'b0;
        ch_memread = '0;
        ch_memwr   = '0;
    endtask

    // Issue a request on one channel for a single cycle.
    task automatic request(input int ch, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
        ihit = 1'b1;
        if (wr) ch_memwr[ch] = 1'b1;
        else    ch_memread[ch] = 1'b1;
        ch_addr[ch*AW +: AW]  = a;
        ch_wdata[ch*DW +: DW] = wd;
    endtask

    // Pulse dhit for one edge and return the ch_hit/ch_rdata seen after it.
    task automatic serve(input logic [DW-1:0] ld, output logic [NCH-1:0] hv,
                         output logic [DW-1:0] rd);
        dhit  = 1'b1;
        dload = ld;
        tick();
        hv    = ch_hit;
        rd    = ch_rdata;
        dhit  = 1'b0;
        dload = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; clear_req(); ch_addr = '0; ch_wdata = '0; dhit = 1'b0; dload = '0;
        tick(); tick();
        RST = 1'b0;
        total++; if (dREN !== 1'b0 || dWEN !== 1'b0) begin bad++;
            $display("FAIL reset_en: dREN=%0b dWEN=%0b want 0 0", dREN, dWEN); end
        total++; if (ch_busy !== 2'b00 || ch_hit !== 2'b00) begin bad++;
            $display("FAIL reset_ch: busy=%b hit=%b want 00 00", ch_busy, ch_hit); end
        total++; if (daddr !== 32'h0 || dstore !== 32'h0 || ch_rdata !== 32'h0 || timeout_err !== 1'b0) begin bad++;
            $display("FAIL reset_data: daddr=%h dstore=%h rdata=%h terr=%b want 0", daddr, dstore, ch_rdata, timeout_err); end
    endtask

    task automatic test_single_read();
        logic [NCH-1:0] hv; logic [DW-1:0] rd;
        request(0, 1'b0, 32'h100, 32'h0);
        tick(); clear_req();
        total++; if (ch_busy !== 2'b01 || dREN !== 1'b0) begin bad++;
            $display("FAIL rd_capture: busy=%b dREN=%b want 01 0", ch_busy, dREN); end
        tick();
        total++; if (dREN !== 1'b1 || dWEN !== 1'b0 || daddr !== 32'h100) begin bad++;
            $display("FAIL rd_issue: dREN=%b dWEN=%b daddr=%h want 1 0 100", dREN, dWEN, daddr); end
        tick();
        total++; if (dREN !== 1'b1 || daddr !== 32'h100 || ch_hit !== 2'b00) begin bad++;
            $display("FAIL rd_hold: dREN=%b daddr=%h hit=%b want 1 100 00", dREN, daddr, ch_hit); end
        serve(32'hDEADBEEF, hv, rd);
        total++; if (hv !== 2'b01 || rd !== 32'hDEADBEEF) begin bad++;
            $display("FAIL rd_hit: hit=%b rdata=%h want 01 deadbeef", hv, rd); end
        total++; if (dREN !== 1'b0 || ch_busy !== 2'b00) begin bad++;
            $display("FAIL rd_done: dREN=%b busy=%b want 0 00", dREN, ch_busy); end
        tick();
        total++; if (ch_hit !== 2'b00) begin bad++;
            $display("FAIL rd_pulse: hit=%b want 00", ch_hit); end
    endtask

    task automatic test_single_write();
        logic [NCH-1:0] hv; logic [DW-1:0] rd;
        request(1, 1'b1, 32'h200, 32'h12345678);
        tick(); clear_req(); tick();
        total++; if (dWEN !== 1'b1 || dREN !== 1'b0 || dstore !== 32'h12345678 || daddr !== 32'h200) begin bad++;
            $display("FAIL wr_issue: dWEN=%b dREN=%b dstore=%h daddr=%h want 1 0 12345678 200", dWEN, dREN, dstore, daddr); end
        serve(32'hFFFF0000, hv, rd);
        total++; if (hv !== 2'b10 || rd !== 32'h0 || ch_busy !== 2'b00 || dWEN !== 1'b0) begin bad++;
            $display("FAIL wr_hit: hit=%b rdata=%h busy=%b dWEN=%b want 10 0 00 0", hv, rd, ch_busy, dWEN); end
        // read and write together on channel 0: the write is performed
        request(0, 1'b1, 32'h240, 32'hA5A5A5A5);
        ch_memread[0] = 1'b1;
        tick(); clear_req(); tick();
        total++; if (dWEN !== 1'b1 || dREN !== 1'b0 || dstore !== 32'hA5A5A5A5) begin bad++;
            $display("FAIL wr_wins: dWEN=%b dREN=%b dstore=%h want 1 0 a5a5a5a5", dWEN, dREN, dstore); end
        serve(32'h1, hv, rd);
        total++; if (hv !== 2'b01 || rd !== 32'h0) begin bad++;
            $display("FAIL wr_wins_hit: hit=%b rdata=%h want 01 0", hv, rd); end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] hv; logic [DW-1:0] rd;
        // last grant is channel 0 here, so channel 1 goes first
        request(0, 1'b0, 32'h300, 32'h0); request(1, 1'b0, 32'h400, 32'h0);
        tick(); clear_req(); tick();
        total++; if (daddr !== 32'h400 || dREN !== 1'b1) begin bad++;
            $display("FAIL rr_first: daddr=%h dREN=%b want 400 1", daddr, dREN); end
        serve(32'h11, hv, rd);
        total++; if (hv !== 2'b10 || rd !== 32'h11 || ch_busy !== 2'b01) begin bad++;
            $display("FAIL rr_first_hit: hit=%b rdata=%h busy=%b want 10 11 01", hv, rd, ch_busy); end
        tick();
        total++; if (daddr !== 32'h300 || dREN !== 1'b1 || ch_hit !== 2'b00) begin bad++;
            $display("FAIL rr_b2b: daddr=%h dREN=%b hit=%b want 300 1 00", daddr, dREN, ch_hit); end
        serve(32'h22, hv, rd);
        total++; if (hv !== 2'b01 || rd !== 32'h22) begin bad++;
            $display("FAIL rr_second_hit: hit=%b rdata=%h want 01 22", hv, rd); end
        // last grant is channel 0 again: channel 1 first once more
        request(1, 1'b0, 32'h500, 32'h0);
        tick(); clear_req(); tick();
        serve(32'h33, hv, rd);
        total++; if (hv !== 2'b10) begin bad++;
            $display("FAIL rr_single: hit=%b want 10", hv); end
        // last grant is now channel 1: channel 0 first
        request(0, 1'b0, 32'h600, 32'h0); request(1, 1'b0, 32'h700, 32'h0);
        tick(); clear_req(); tick();
        total++; if (daddr !== 32'h600) begin bad++;
            $display("FAIL rr_third: daddr=%h want 600", daddr); end
        serve(32'h44, hv, rd);
        total++; if (hv !== 2'b01) begin bad++;
            $display("FAIL rr_third_hit: hit=%b want 01", hv); end
        tick();
        total++; if (daddr !== 32'h700) begin bad++;
            $display("FAIL rr_fourth: daddr=%h want 700", daddr); end
        serve(32'h55, hv, rd);
        total++; if (hv !== 2'b10 || ch_busy !== 2'b00) begin bad++;
            $display("FAIL rr_fourth_hit: hit=%b busy=%b want 10 00", hv, ch_busy); end
    endtask

    task automatic test_gating();
        logic [NCH-1:0] hv; logic [DW-1:0] rd;
        request(0, 1'b0, 32'h780, 32'h0);
        ihit = 1'b0;
        tick(); clear_req();
        total++; if (ch_busy !== 2'b00) begin bad++;
            $display("FAIL gate_ihit_busy: busy=%b want 00", ch_busy); end
        tick();
        total++; if (dREN !== 1'b0) begin bad++;
            $display("FAIL gate_ihit_dren: dREN=%b want 0", dREN); end
        // request held while busy: new address must not replace the latched one
        request(0, 1'b0, 32'h800, 32'h0);
        tick();
        ch_addr[0 +: AW] = 32'h900;
        tick(); tick();
        total++; if (daddr !== 32'h800 || dREN !== 1'b1) begin bad++;
            $display("FAIL gate_busy_addr: daddr=%h dREN=%b want 800 1", daddr, dREN); end
        clear_req();
        serve(32'h66, hv, rd);
        total++; if (hv !== 2'b01) begin bad++;
            $display("FAIL gate_busy_hit: hit=%b want 01", hv); end
        tick(); tick();
        total++; if (ch_hit !== 2'b00 || dREN !== 1'b0 || ch_busy !== 2'b00) begin bad++;
            $display("FAIL gate_one_hit: hit=%b dREN=%b busy=%b want 00 0 00", ch_hit, dREN, ch_busy); end
        // dhit in IDLE does nothing
        serve(32'h77, hv, rd);
        total++; if (hv !== 2'b00 || dREN !== 1'b0 || dWEN !== 1'b0) begin bad++;
            $display("FAIL gate_spurious: hit=%b dREN=%b dWEN=%b want 00 0 0", hv, dREN, dWEN); end
    endtask

    task automatic test_reset_mid_access();
        request(1, 1'b0, 32'hA00, 32'h0);
        tick(); clear_req(); tick();
        total++; if (dREN !== 1'b1) begin bad++;
            $display("FAIL rst_mid_pre: dREN=%b want 1", dREN); end
        RST = 1'b1; dhit = 1'b1; dload = 32'hBAD;
        tick();
        RST = 1'b0; dhit = 1'b0; dload = '0;
        total++; if (dREN !== 1'b0 || ch_busy !== 2'b00 || ch_hit !== 2'b00) begin bad++;
            $display("FAIL rst_mid: dREN=%b busy=%b hit=%b want 0 00 00", dREN, ch_busy, ch_hit); end
        tick();
        total++; if (ch_hit !== 2'b00 || dREN !== 1'b0) begin bad++;
            $display("FAIL rst_mid_after: hit=%b dREN=%b want 00 0", ch_hit, dREN); end
    endtask

    task automatic test_timeout();
        logic [NCH-1:0] hv; logic [DW-1:0] rd;
        request(0, 1'b0, 32'hB00, 32'h0);
        tick(); clear_req(); tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
`ifdef MULTI_REQUEST_UNIT_TIMEOUT_EN
            total++; if (timeout_err !== (i >= 8)) begin bad++;
                $display("FAIL tmo_wait%0d: terr=%b want %0b", i, timeout_err, (i >= 8)); end
`else
            total++; if (timeout_err !== 1'b0) begin bad++;
                $display("FAIL tmo_off%0d: terr=%b want 0", i, timeout_err); end
`endif
        end
        serve(32'h88, hv, rd);
        total++; if (hv !== 2'b01 || rd !== 32'h88) begin bad++;
            $display("FAIL tmo_hit: hit=%b rdata=%h want 01 88", hv, rd); end
        tick();
`ifdef MULTI_REQUEST_UNIT_TIMEOUT_EN
        total++; if (timeout_err !== 1'b1) begin bad++;
            $display("FAIL tmo_sticky: terr=%b want 1", timeout_err); end
`else
        total++; if (timeout_err !== 1'b0) begin bad++;
            $display("FAIL tmo_off_end: terr=%b want 0", timeout_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_gating();
        test_reset_mid_access();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
